// File: rtl/seg7_scan.sv
// Time-multiplexed hex display driver with frame-synchronous update of the shown data.
// Optional anode dead-time at the start of each slot: define SEG7_DEADTIME_EN.
module seg7_scan #(
   parameter int CLK_HZ   = 100000000,
   parameter int SCAN_HZ  = 250,
   parameter int DIGITS   = 4,
   parameter int DEAD_CYC = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic                  load,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic                  dp_n,
   output logic                  frame_tick,
   output logic                  upd_pend
);

   localparam int K  = CLK_HZ / (SCAN_HZ * DIGITS);
   localparam int CW = (K > 1) ? $clog2(K) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] K_LAST = CW'(K - 1);
   localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);
   localparam logic [CW-1:0] DEAD_C = CW'(DEAD_CYC);
`ifdef SEG7_DEADTIME_EN
   localparam bit DEAD_EN = 1'b1;
`else
   localparam bit DEAD_EN = 1'b0;
`endif

   if (K < 2) begin : g_bad_k
      $error("seg7_scan: slot length CLK_HZ/(SCAN_HZ*DIGITS) must be at least 2");
   end
   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("seg7_scan: DIGITS must be in 1..8");
   end
`ifdef SEG7_DEADTIME_EN
   if (DEAD_CYC >= K) begin : g_bad_dead
      $error("seg7_scan: DEAD_CYC must be smaller than the slot length");
   end
`endif

   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'h40;
         4'h1:    g = 7'h79;
         4'h2:    g = 7'h24;
         4'h3:    g = 7'h30;
         4'h4:    g = 7'h19;
         4'h5:    g = 7'h12;
         4'h6:    g = 7'h02;
         4'h7:    g = 7'h78;
         4'h8:    g = 7'h00;
         4'h9:    g = 7'h10;
         4'hA:    g = 7'h08;
         4'hB:    g = 7'h03;
         4'hC:    g = 7'h46;
         4'hD:    g = 7'h21;
         4'hE:    g = 7'h06;
         4'hF:    g = 7'h0E;
         default: g = 7'h7F;
      endcase
      return g;
   endfunction

   logic [CW-1:0]       count_r, count_nx_s;
   logic [IW-1:0]       index_r, index_nx_s;
   logic [4*DIGITS-1:0] pend_val_r, act_val_r;
   logic [DIGITS-1:0]   pend_dp_r, act_dp_r, pend_blank_r, act_blank_r;
   logic [IW+1:0]       base_s;
   logic [3:0]          nib_s;
   logic                dead_s;
   logic [DIGITS-1:0]   an_nx_s;
   logic [6:0]          seg_nx_s;
   logic                dpn_nx_s;

   // Slot counter and digit index next-state.
   always_comb begin
      count_nx_s = count_r + {{(CW-1){1'b0}}, 1'b1};
      index_nx_s = index_r;
      if (count_r == K_LAST) begin
         count_nx_s = {CW{1'b0}};
         if (index_r == I_LAST) begin
            index_nx_s = {IW{1'b0}};
         end else begin
            index_nx_s = index_r + {{(IW-1){1'b0}}, 1'b1};
         end
      end else begin
         index_nx_s = index_r;
      end
   end

   // Scan position state; frame_tick is registered from the next state so it is
   // high exactly in the last cycle of the last slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r    <= {CW{1'b0}};
         index_r    <= {IW{1'b0}};
         frame_tick <= 1'b0;
      end else begin
         count_r    <= count_nx_s;
         index_r    <= index_nx_s;
         frame_tick <= (count_nx_s == K_LAST) && (index_nx_s == I_LAST);
      end
   end

   // Pending/active data registers; active only changes on a frame boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_val_r   <= {(4*DIGITS){1'b0}};
         pend_dp_r    <= {DIGITS{1'b0}};
         pend_blank_r <= {DIGITS{1'b1}};
         act_val_r    <= {(4*DIGITS){1'b0}};
         act_dp_r     <= {DIGITS{1'b0}};
         act_blank_r  <= {DIGITS{1'b1}};
         upd_pend     <= 1'b0;
      end else begin
         if (frame_tick) begin
            act_val_r   <= pend_val_r;
            act_dp_r    <= pend_dp_r;
            act_blank_r <= pend_blank_r;
         end
         if (load) begin
            pend_val_r   <= value;
            pend_dp_r    <= dp;
            pend_blank_r <= blank;
            upd_pend     <= 1'b1;
         end else if (frame_tick) begin
            upd_pend     <= 1'b0;
         end
      end
   end

   // Output decode for the current digit.
   always_comb begin
      base_s = {index_r, 2'b00};
      nib_s  = act_val_r[base_s +: 4];
      dead_s = DEAD_EN && (count_r < DEAD_C);
      if (act_blank_r[index_r]) begin
         an_nx_s  = {DIGITS{1'b1}};
         seg_nx_s = 7'h7F;
         dpn_nx_s = 1'b1;
      end else begin
         an_nx_s  = dead_s ? {DIGITS{1'b1}} : ~(DIGITS'(1) << index_r);
         seg_nx_s = hex_glyph(nib_s);
         dpn_nx_s = ~act_dp_r[index_r];
      end
   end

   // Registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an   <= {DIGITS{1'b1}};
         seg  <= 7'h7F;
         dp_n <= 1'b1;
      end else begin
         an   <= an_nx_s;
         seg  <= seg_nx_s;
         dp_n <= dpn_nx_s;
      end
   end

endmodule
